// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding in regfile_sb.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int AW_DEF = addr_w(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one busy bit per register and a live count of set bits.
// iss_ready is combinational and blocks a second reservation until the pending write retires.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = addr_w(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [NREGS-1:0] busy,
  output logic [CW-1:0]    busy_cnt
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_hit, iss_acc, wr_clr, inc, dec;

  always_comb begin
    wr_hit    = wr_en && (wr_addr == iss_addr);
    iss_ready = (iss_addr == '0) || !busy_q[iss_addr] || wr_hit;
    iss_acc   = iss_valid && iss_ready && (iss_addr != '0);
    wr_clr    = wr_en && (wr_addr != '0);

    busy_d = busy_q;
    if (wr_clr)  busy_d[wr_addr]  = 1'b0;
    if (iss_acc) busy_d[iss_addr] = 1'b1;

    // Same-address issue+write leaves the bit set, so neither side moves the count.
    inc   = iss_acc && !busy_q[iss_addr];
    dec   = wr_clr && busy_q[wr_addr] && !(iss_acc && wr_hit);
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-pending scoreboard: zero-latency reads, writes/reservations on the clock edge.
// iss_ready stalls a reservation on a busy register; REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = addr_w(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_addr,
  output logic                      iss_ready,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  output logic [CW-1:0]             busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clock     (clock),
    .nreset    (nreset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = (rd_addr[p] == '0) ? '0 : regs_q[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr[p])) begin
        rd_data[p] = wr_data;
        rd_busy[p] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomised run against a behavioural model.
// Expectations are queued when stimulus is applied and popped when the outputs are sampled.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);
  localparam int CW    = $clog2(NREGS + 1);

  logic                     clock = 1'b0;
  logic                     nreset;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic                     iss_valid;
  logic [AW-1:0]            iss_addr;
  logic                     iss_ready;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic [CW-1:0]            busy_cnt;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_cnt  (busy_cnt)
  );

  always #5 clock = ~clock;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [63:0]     exp_q[$];
  logic [XLEN-1:0] mem_m  [NREGS];
  logic            busy_m [NREGS];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk_pop(input string tag, input logic [63:0] obs);
    if (exp_q.size() == 0) check_eq({tag, "_no_expectation"}, 64'(exp_q.size()), 64'd1);
    else                   check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic drive(input logic iv, input int ia, input logic we, input int wa,
                       input logic [XLEN-1:0] wd);
    iss_valid = iv;
    iss_addr  = AW'(ia);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = wd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += busy_m[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic model_ready();
    return (iss_addr == 0) || !busy_m[iss_addr] || (wr_en && wr_addr == iss_addr);
  endfunction

  // Advance one clock edge, updating the model with the inputs presented on that edge.
  task automatic tick();
    logic ok;
    if (nreset) begin
      ok = iss_valid && model_ready();
      if (wr_en && wr_addr != 0) begin
        mem_m[wr_addr]  = wr_data;
        busy_m[wr_addr] = 1'b0;
      end
      if (ok && iss_addr != 0) busy_m[iss_addr] = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] d;
    logic            b;
    int              a;

    nreset  = 1'b0;
    rd_addr = '0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    rd_addr[0] = AW'(5);
    rd_addr[1] = AW'(0);
    exp_push(0); chk_pop("rst_rd_data0", rd_data[0]);
    exp_push(0); chk_pop("rst_rd_busy", rd_busy);
    exp_push(0); chk_pop("rst_busy_cnt", busy_cnt);
    exp_push(1); chk_pop("rst_iss_ready", iss_ready);
    #2 nreset = 1'b1;
    tick();

    // Mid-cycle reset discards data and reservations
    drive(1, 4, 1, 5, 32'hDEAD_BEEF);
    tick();
    drive(0, 4, 0, 0, '0);
    rd_addr[0] = AW'(5);
    rd_addr[1] = AW'(4);
    #1;
    exp_push(32'hDEAD_BEEF); chk_pop("x5_written", rd_data[0]);
    exp_push(1);             chk_pop("cnt_before_rst", busy_cnt);
    exp_push(0);             chk_pop("x4_ready_while_busy", iss_ready);
    #1 nreset = 1'b0;
    #1;
    exp_push(0); chk_pop("x5_after_rst", rd_data[0]);
    exp_push(0); chk_pop("cnt_after_rst", busy_cnt);
    exp_push(0); chk_pop("x4_busy_after_rst", rd_busy[1]);
    exp_push(1); chk_pop("ready_after_rst", iss_ready);
    model_reset();
    #2 nreset = 1'b1;
    tick();

    // x0 is hardwired
    drive(1, 0, 0, 0, '0);
    #1;
    exp_push(1); chk_pop("x0_iss_ready", iss_ready);
    tick();
    drive(0, 0, 1, 0, 32'h1234);
    tick();
    drive(0, 0, 0, 0, '0);
    rd_addr[0] = '0;
    rd_addr[1] = '0;
    #1;
    exp_push(0); chk_pop("x0_rd_data", rd_data[0]);
    exp_push(0); chk_pop("x0_rd_busy", rd_busy[0]);
    exp_push(0); chk_pop("x0_busy_cnt", busy_cnt);
    exp_push(1); chk_pop("x0_ready_after", iss_ready);

    // WAW block on x3
    rd_addr[0] = AW'(3);
    drive(1, 3, 0, 0, '0);
    tick();
    #1;
    exp_push(0); chk_pop("x3_reissue_ready", iss_ready);
    exp_push(1); chk_pop("x3_cnt", busy_cnt);
    exp_push(1); chk_pop("x3_rd_busy", rd_busy[0]);
    tick();
    exp_push(1); chk_pop("x3_cnt_held", busy_cnt);
    drive(0, 3, 1, 3, 32'h55);
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    exp_push(0);     chk_pop("x3_busy_cleared", rd_busy[0]);
    exp_push(0);     chk_pop("x3_cnt_cleared", busy_cnt);
    exp_push(32'h55); chk_pop("x3_data", rd_data[0]);

    // Same-edge issue and write on busy x7
    rd_addr[0] = AW'(7);
    drive(1, 7, 0, 0, '0);
    tick();
    drive(1, 7, 1, 7, 32'hA5);
    #1;
    exp_push(1); chk_pop("x7_ready_same_edge", iss_ready);
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    exp_push(32'hA5); chk_pop("x7_data", rd_data[0]);
    exp_push(1);      chk_pop("x7_still_busy", rd_busy[0]);
    exp_push(1);      chk_pop("x7_cnt", busy_cnt);
    drive(0, 0, 1, 7, 32'hA5);
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    exp_push(0); chk_pop("x7_cnt_cleared", busy_cnt);

    // Write forwarding on x9 (old data 0x11)
    drive(0, 0, 1, 9, 32'h11);
    tick();
    drive(1, 9, 0, 0, '0);
    tick();
    rd_addr[0] = AW'(9);
    rd_addr[1] = AW'(9);
    drive(0, 0, 1, 9, 32'h77);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_push(32'h77); chk_pop("x9_byp_p0", rd_data[0]);
    exp_push(32'h77); chk_pop("x9_byp_p1", rd_data[1]);
    exp_push(2'b00);  chk_pop("x9_byp_busy", rd_busy);
`else
    exp_push(32'h11); chk_pop("x9_old_p0", rd_data[0]);
    exp_push(32'h11); chk_pop("x9_old_p1", rd_data[1]);
    exp_push(2'b11);  chk_pop("x9_old_busy", rd_busy);
`endif
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    exp_push(32'h77); chk_pop("x9_new_p0", rd_data[0]);
    exp_push(32'h77); chk_pop("x9_new_p1", rd_data[1]);
    exp_push(2'b00);  chk_pop("x9_new_busy", rd_busy);

    // Fill and drain every register
    for (int i = 1; i < NREGS; i++) begin
      drive(1, i, 0, 0, '0);
      tick();
    end
    drive(0, 5, 0, 0, '0);
    #1;
    exp_push(31); chk_pop("fill_cnt", busy_cnt);
    exp_push(0);  chk_pop("fill_x5_ready", iss_ready);
    for (int i = 1; i < NREGS; i++) begin
      drive(0, 0, 1, i, XLEN'(32'h1000 + i));
      tick();
    end
    drive(0, 0, 0, 0, '0);
    rd_addr[0] = AW'(1);
    rd_addr[1] = AW'(31);
    #1;
    exp_push(0);            chk_pop("drain_cnt", busy_cnt);
    exp_push(32'h1001);     chk_pop("drain_x1", rd_data[0]);
    exp_push(32'h101F);     chk_pop("drain_x31", rd_data[1]);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, NREGS - 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, NREGS - 1), $urandom);
      for (int p = 0; p < NRD; p++)
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = int'(rd_addr[p]);
        d = (a == 0) ? '0 : mem_m[a];
        b = (a != 0) && busy_m[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 0 && int'(wr_addr) == a) begin
          d = wr_data;
          b = 1'b0;
        end
`endif
        exp_push(d);
        exp_push(b);
      end
      exp_push(model_ready());
      exp_push(model_cnt());
      for (int p = 0; p < NRD; p++) begin
        chk_pop($sformatf("rnd%0d_rd%0d_data", c, p), rd_data[p]);
        chk_pop($sformatf("rnd%0d_rd%0d_busy", c, p), rd_busy[p]);
      end
      chk_pop($sformatf("rnd%0d_iss_ready", c), iss_ready);
      chk_pop($sformatf("rnd%0d_busy_cnt", c), busy_cnt);
      tick();
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
